// File: rtl/fetch_unit_if.sv
// Strobe, RAM and status bundle between the control unit (master) and the fetch datapath (slave).
// All slave outputs are registered copies of fetch-unit state; there is no handshake or backpressure.
interface fetch_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic              mar_we;
  logic [1:0]        ram_in;
  logic              pc_inc;
  logic              mbr_we;
  logic              mbr_mux;
  logic              ir_we;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] acc_in;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] fu_ir;
  logic [ADDR_W-1:0] fu_pc;
  logic              ir_valid;
  logic [CNT_W-1:0]  fetch_cnt;
  logic              seq_err;

  modport master (
    output mar_we, ram_in, pc_inc, mbr_we, mbr_mux, ir_we, ram_rdata, acc_in,
    input  ram_addr, ram_wdata, fu_ir, fu_pc, ir_valid, fetch_cnt, seq_err
  );

  modport slave (
    input  mar_we, ram_in, pc_inc, mbr_we, mbr_mux, ir_we, ram_rdata, acc_in,
    output ram_addr, ram_wdata, fu_ir, fu_pc, ir_valid, fetch_cnt, seq_err
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch datapath (PC/MAR/MBR/IR) with a fetch-protocol monitor; all outputs registered, 1-cycle load latency.
// No backpressure: control-unit strobes are always accepted, the monitor only observes them.
module fetch_unit #(
  parameter int               ADDR_W   = 8,
  parameter int               DATA_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int               CNT_W    = 16
) (
  input  logic      fu_clk,
  input  logic      fu_rst,
  fetch_unit_if.slave fu
);

  typedef enum logic [1:0] {M_IDLE, M_ADDR, M_DATA} mon_t;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mbr;
  logic [DATA_W-1:0] ir;
  logic              ir_valid;
  logic [CNT_W-1:0]  fetch_cnt;
  logic              seq_err;
  mon_t              mon;

  logic [ADDR_W-1:0] mar_src;
  logic              mar_from_pc;

  assign mar_from_pc = fu.mar_we && (fu.ram_in == 2'b00);

  always_comb begin
    mar_src = mar;
    case (fu.ram_in)
      2'b00:   mar_src = pc;
      2'b01:   mar_src = ADDR_W'(mbr);
      2'b10:   mar_src = ADDR_W'(ir[3:0]);
      default: mar_src = mar;
    endcase
  end

  // Every register samples pre-edge values, so back-to-back strobes chain naturally.
  always_ff @(posedge fu_clk or posedge fu_rst) begin
    if (fu_rst) begin
      pc        <= RESET_PC;
      mar       <= '0;
      mbr       <= '0;
      ir        <= '0;
      ir_valid  <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      if (fu.pc_inc) pc <= pc + ADDR_W'(1);
      if (fu.mar_we) mar <= mar_src;
      if (fu.mbr_we) mbr <= fu.mbr_mux ? fu.acc_in : fu.ram_rdata;
      if (fu.ir_we) begin
        ir        <= mbr;
        ir_valid  <= 1'b1;
        fetch_cnt <= fetch_cnt + CNT_W'(1);
      end
    end
  end

  // Monitor: an instruction fetch must go address -> data -> IR; operand traffic in M_IDLE is legal.
  always_ff @(posedge fu_clk or posedge fu_rst) begin
    if (fu_rst) begin
      mon     <= M_IDLE;
      seq_err <= 1'b0;
    end else begin
      case (mon)
        M_IDLE: begin
          if (fu.pc_inc && !fu.mar_we) seq_err <= 1'b1;
          if (mar_from_pc) mon <= M_ADDR;
        end
        M_ADDR: begin
          if (fu.mbr_we && !fu.mbr_mux) begin
            mon <= M_DATA;
          end else if (fu.ir_we) begin
            seq_err <= 1'b1;
            mon     <= M_IDLE;
          end
        end
        M_DATA: begin
          if (fu.ir_we) begin
            mon <= M_IDLE;
          end else if (mar_from_pc) begin
            seq_err <= 1'b1;
            mon     <= M_ADDR;
          end
        end
        default: mon <= M_IDLE;
      endcase
    end
  end

  assign fu.ram_addr  = mar;
  assign fu.ram_wdata = mbr;
  assign fu.fu_ir     = ir;
  assign fu.fu_pc     = pc;
  assign fu.ir_valid  = ir_valid;
  assign fu.fetch_cnt = fetch_cnt;
  assign fu.seq_err   = seq_err;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a transaction-level model tracks expected state, a negedge process compares it.
module tb_fetch_unit;

  logic fu_clk = 1'b0;
  logic fu_rst = 1'b1;
  always #5 fu_clk = ~fu_clk;

  fetch_unit_if #(.ADDR_W(8), .DATA_W(8), .CNT_W(16)) fu_bus ();

  fetch_unit #(.ADDR_W(8), .DATA_W(8), .RESET_PC(8'h00), .CNT_W(16)) dut (
    .fu_clk (fu_clk),
    .fu_rst (fu_rst),
    .fu     (fu_bus)
  );

  logic [7:0] ram [256];
  assign fu_bus.ram_rdata = ram[fu_bus.ram_addr];

  int passed = 0;
  int total  = 0;
  bit check_en = 1'b0;

  // Expected architectural state; phase 0 = between fetches, 1 = address sent, 2 = data captured.
  logic [7:0]  m_pc, m_mar, m_mbr, m_ir;
  logic        m_valid, m_err;
  logic [15:0] m_cnt;
  int          m_phase;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  task automatic model_reset();
    m_pc = 8'h00; m_mar = 8'h00; m_mbr = 8'h00; m_ir = 8'h00;
    m_valid = 1'b0; m_cnt = 16'h0; m_err = 1'b0; m_phase = 0;
  endtask

  always @(negedge fu_clk) begin
    if (check_en) begin
      chk("ram_addr",  {24'h0, fu_bus.ram_addr},  {24'h0, m_mar});
      chk("ram_wdata", {24'h0, fu_bus.ram_wdata}, {24'h0, m_mbr});
      chk("fu_ir",     {24'h0, fu_bus.fu_ir},     {24'h0, m_ir});
      chk("fu_pc",     {24'h0, fu_bus.fu_pc},     {24'h0, m_pc});
      chk("ir_valid",  {31'h0, fu_bus.ir_valid},  {31'h0, m_valid});
      chk("fetch_cnt", {16'h0, fu_bus.fetch_cnt}, {16'h0, m_cnt});
      chk("seq_err",   {31'h0, fu_bus.seq_err},   {31'h0, m_err});
    end
  end

  // Apply one cycle of strobes, then advance the model by the architectural rules.
  task automatic cyc(input logic mw, input logic [1:0] ri, input logic pi,
                     input logic bw, input logic bm, input logic iw);
    logic [7:0]  n_pc, n_mar, n_mbr, n_ir;
    logic [15:0] n_cnt;
    logic        n_valid, n_err;
    int          n_phase;
    fu_bus.mar_we = mw; fu_bus.ram_in = ri; fu_bus.pc_inc = pi;
    fu_bus.mbr_we = bw; fu_bus.mbr_mux = bm; fu_bus.ir_we = iw;
    n_pc = pi ? m_pc + 8'd1 : m_pc;
    n_mar = m_mar;
    if (mw) begin
      if (ri == 2'd0)      n_mar = m_pc;
      else if (ri == 2'd1) n_mar = m_mbr;
      else if (ri == 2'd2) n_mar = {4'h0, m_ir[3:0]};
    end
    n_mbr = bw ? (bm ? fu_bus.acc_in : ram[m_mar]) : m_mbr;
    n_ir = iw ? m_mbr : m_ir;
    n_valid = m_valid | iw;
    n_cnt = iw ? m_cnt + 16'd1 : m_cnt;
    n_err = m_err;
    n_phase = m_phase;
    if (m_phase == 0) begin
      if (pi && !mw) n_err = 1'b1;
      if (mw && ri == 2'd0) n_phase = 1;
    end else if (m_phase == 1) begin
      if (bw && !bm) n_phase = 2;
      else if (iw) begin n_err = 1'b1; n_phase = 0; end
    end else begin
      if (iw) n_phase = 0;
      else if (mw && ri == 2'd0) begin n_err = 1'b1; n_phase = 1; end
    end
    @(posedge fu_clk);
    #1;
    m_pc = n_pc; m_mar = n_mar; m_mbr = n_mbr; m_ir = n_ir;
    m_valid = n_valid; m_cnt = n_cnt; m_err = n_err; m_phase = n_phase;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic fetch();
    cyc(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    fu_rst = 1'b1;
    fu_bus.mar_we = 1'b0; fu_bus.ram_in = 2'b00; fu_bus.pc_inc = 1'b0;
    fu_bus.mbr_we = 1'b0; fu_bus.mbr_mux = 1'b0; fu_bus.ir_we = 1'b0;
    #1;
    model_reset();
    @(posedge fu_clk);
    #1;
    fu_rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'h5A;
    ram[0] = 8'h31;
    ram[1] = 8'h47;
    fu_bus.acc_in = 8'h00;
    do_reset();
    check_en = 1'b1;

    // Reset state after idling
    idle(3);
    chk("rst_pc", {24'h0, fu_bus.fu_pc}, 32'h00);
    chk("rst_addr", {24'h0, fu_bus.ram_addr}, 32'h00);
    chk("rst_ir", {24'h0, fu_bus.fu_ir}, 32'h00);
    chk("rst_valid", {31'h0, fu_bus.ir_valid}, 32'h0);
    chk("rst_err", {31'h0, fu_bus.seq_err}, 32'h0);

    // Nominal fetch of RAM[0]
    fetch();
    chk("fetch_ir", {24'h0, fu_bus.fu_ir}, 32'h31);
    chk("fetch_pc", {24'h0, fu_bus.fu_pc}, 32'h01);
    chk("fetch_cnt1", {16'h0, fu_bus.fetch_cnt}, 32'h1);
    chk("fetch_err", {31'h0, fu_bus.seq_err}, 32'h0);

    // Accumulator capture leaves IR alone
    fu_bus.acc_in = 8'hA5;
    cyc(1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("acc_wdata", {24'h0, fu_bus.ram_wdata}, 32'hA5);
    chk("acc_ir", {24'h0, fu_bus.fu_ir}, 32'h31);

    // MAR sources: IR nibble, hold, MBR
    cyc(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mar_irnib", {24'h0, fu_bus.ram_addr}, 32'h01);
    cyc(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mar_hold", {24'h0, fu_bus.ram_addr}, 32'h01);
    cyc(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mar_mbr", {24'h0, fu_bus.ram_addr}, 32'h47);

    // Same-edge: MAR from old IR while IR loads; IR from old MBR while MBR loads
    cyc(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("same_mar", {24'h0, fu_bus.ram_addr}, 32'h01);
    chk("same_ir", {24'h0, fu_bus.fu_ir}, 32'h47);
    fu_bus.acc_in = 8'h5C;
    cyc(1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("old_mbr_ir", {24'h0, fu_bus.fu_ir}, 32'h5C);
    chk("new_mbr", {24'h0, fu_bus.ram_wdata}, 32'h47);
    chk("cnt3", {16'h0, fu_bus.fetch_cnt}, 32'h3);

    // MAR gets old PC while PC increments; then run PC to the wrap point
    for (int i = 0; i < 4; i++) cyc(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("pcinc_addr", {24'h0, fu_bus.ram_addr}, 32'h05);
    chk("pcinc_pc", {24'h0, fu_bus.fu_pc}, 32'h06);
    for (int i = 0; i < 249; i++) cyc(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("pc_ff", {24'h0, fu_bus.fu_pc}, 32'hFF);
    cyc(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("pc_wrap", {24'h0, fu_bus.fu_pc}, 32'h00);
    chk("wrap_noerr", {31'h0, fu_bus.seq_err}, 32'h0);
    cyc(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 2'b00, 1'b0, 0, 1'b0, 1'b1);

    // IR load straight after the address phase is a protocol error, and it sticks
    cyc(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("skip_mbr_err", {31'h0, fu_bus.seq_err}, 32'h1);
    fetch();
    chk("err_sticky", {31'h0, fu_bus.seq_err}, 32'h1);
    chk("refetch_ir", {24'h0, fu_bus.fu_ir}, 32'h31);
    chk("refetch_pc", {24'h0, fu_bus.fu_pc}, 32'h01);

    // Reset asserted mid-fetch, after the MBR load
    cyc(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    fu_rst = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_pc", {24'h0, fu_bus.fu_pc}, 32'h00);
    chk("mid_rst_addr", {24'h0, fu_bus.ram_addr}, 32'h00);
    chk("mid_rst_wdata", {24'h0, fu_bus.ram_wdata}, 32'h00);
    chk("mid_rst_ir", {24'h0, fu_bus.fu_ir}, 32'h00);
    chk("mid_rst_valid", {31'h0, fu_bus.ir_valid}, 32'h0);
    chk("mid_rst_cnt", {16'h0, fu_bus.fetch_cnt}, 32'h0);
    chk("mid_rst_err", {31'h0, fu_bus.seq_err}, 32'h0);
    do_reset();

    // PC moved outside a fetch
    cyc(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("stray_pcinc_err", {31'h0, fu_bus.seq_err}, 32'h1);
    chk("stray_pc", {24'h0, fu_bus.fu_pc}, 32'h01);

    // New address phase while data is pending drops the fetch
    do_reset();
    cyc(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("data_no_err", {31'h0, fu_bus.seq_err}, 32'h0);
    cyc(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("dropped_fetch_err", {31'h0, fu_bus.seq_err}, 32'h1);
    idle(2);

    check_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
